// File: rtl/rf_access_ctrl_if.sv
// Bus bundle for rf_access_ctrl: command handshake, response handshake and
// the register-file strobe/address/data lines.
// slave  : the controller's view.
// master : the view of the surrounding environment (command source,
//          response sink and register file).
interface rf_access_ctrl_if #(
    parameter int ADSize = 5,
    parameter int DASize = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADSize-1:0] cmd_addr_a;
    logic [ADSize-1:0] cmd_addr_b;
    logic [ADSize-1:0] cmd_addr_d;
    logic [DASize-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DASize-1:0] rsp_data1;
    logic [DASize-1:0] rsp_data2;

    logic              rf_enable;
    logic              rf_read;
    logic              rf_write;
    logic [ADSize-1:0] rf_waddr;
    logic [ADSize-1:0] rf_raddr1;
    logic [ADSize-1:0] rf_raddr2;
    logic [DASize-1:0] rf_din;
    logic [DASize-1:0] rf_out1;
    logic [DASize-1:0] rf_out2;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data1, rsp_data2,
        input  rsp_ready,
        output rf_enable, rf_read, rf_write, rf_waddr, rf_raddr1, rf_raddr2, rf_din,
        input  rf_out1, rf_out2
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_addr_d, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data1, rsp_data2,
        output rsp_ready,
        input  rf_enable, rf_read, rf_write, rf_waddr, rf_raddr1, rf_raddr2, rf_din,
        output rf_out1, rf_out2
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequences WRITE / READ / ADD commands onto a 32-entry
// register file that samples on negedge and returns read data that is
// captured on the following posedge.
// Optional feature macro: RFCTL_SAT_EN (ADD result saturates to all-ones on
// carry instead of wrapping).
module rf_access_ctrl #(
    parameter int ADSize      = 5,
    parameter int DASize      = 8,
    parameter int STP_REGSize = 32
) (
    input  logic           clk,
    input  logic           rst,
    rf_access_ctrl_if.slave bus
);

    // A register count that the address width cannot reach is a build error.
    if (STP_REGSize > (1 << ADSize)) begin : g_size_check
        $error("rf_access_ctrl: STP_REGSize exceeds the ADSize address range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        ADDWR,
        RESP
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    state_t            state;
    state_t            next_state;

    logic              ready_q;
    logic [1:0]        op_q;
    logic [ADSize-1:0] addr_d_q;
    logic [DASize-1:0] out1_q;
    logic [DASize-1:0] out2_q;

    logic              rsp_valid_q;
    logic [DASize-1:0] rsp_data1_q;
    logic [DASize-1:0] rsp_data2_q;

    logic [ADSize-1:0] rf_waddr_q;
    logic [ADSize-1:0] rf_raddr1_q;
    logic [ADSize-1:0] rf_raddr2_q;
    logic [DASize-1:0] rf_din_q;

    logic              cmd_ready_c;
    logic              accept;
    logic              rsp_done;
    logic              rf_enable_c;
    logic              rf_read_c;
    logic              rf_write_c;

    logic [DASize:0]   add_full;
    logic              add_carry;
    logic [DASize-1:0] add_sum;

    // Commands are only taken in IDLE and never while reset is being applied.
    assign cmd_ready_c = (state == IDLE) && ready_q;
    assign accept      = bus.cmd_valid && cmd_ready_c;
    assign rsp_done    = rsp_valid_q && bus.rsp_ready;

    // Sum of the two captured read values; with saturation a carry pins the
    // result to all-ones while the carry is still reported.
    always_comb begin
        add_full  = {1'b0, out1_q} + {1'b0, out2_q};
        add_carry = add_full[DASize];
`ifdef RFCTL_SAT_EN
        add_sum   = add_carry ? {DASize{1'b1}} : add_full[DASize-1:0];
`else
        add_sum   = add_full[DASize-1:0];
`endif
    end

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-decoded register-file strobes.
    always_comb begin
        next_state  = state;
        rf_enable_c = 1'b0;
        rf_read_c   = 1'b0;
        rf_write_c  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_WRITE: next_state = WR;
                        OP_READ:  next_state = RD;
                        OP_ADD:   next_state = RD;
                        OP_NOP:   next_state = IDLE;
                        default:  next_state = IDLE;
                    endcase
                end
            end
            WR: begin
                rf_enable_c = 1'b1;
                rf_write_c  = 1'b1;
                next_state  = IDLE;
            end
            RD: begin
                rf_enable_c = 1'b1;
                rf_read_c   = 1'b1;
                next_state  = CAP;
            end
            CAP: begin
                next_state = (op_q == OP_ADD) ? ADDWR : RESP;
            end
            ADDWR: begin
                rf_enable_c = 1'b1;
                rf_write_c  = 1'b1;
                next_state  = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Command latching, read capture, result formation and the held
    // address/data lines toward the register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            op_q        <= OP_NOP;
            addr_d_q    <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rf_waddr_q  <= '0;
            rf_raddr1_q <= '0;
            rf_raddr2_q <= '0;
            rf_din_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept) begin
                op_q     <= bus.cmd_op;
                addr_d_q <= bus.cmd_addr_d;
                if (bus.cmd_op == OP_WRITE) begin
                    rf_waddr_q <= bus.cmd_addr_d;
                    rf_din_q   <= bus.cmd_data;
                end
                if (bus.cmd_op == OP_READ || bus.cmd_op == OP_ADD) begin
                    rf_raddr1_q <= bus.cmd_addr_a;
                    rf_raddr2_q <= bus.cmd_addr_b;
                end
            end
            if (state == RD) begin
                out1_q <= bus.rf_out1;
                out2_q <= bus.rf_out2;
            end
            if (state == CAP) begin
                if (op_q == OP_ADD) begin
                    rsp_data1_q <= add_sum;
                    rsp_data2_q <= {{(DASize-1){1'b0}}, add_carry};
                    rf_waddr_q  <= addr_d_q;
                    rf_din_q    <= add_sum;
                end else begin
                    rsp_data1_q <= out1_q;
                    rsp_data2_q <= out2_q;
                end
            end
            rsp_valid_q <= (state == RESP) && !rsp_done;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_data2 = rsp_data2_q;
    assign bus.rf_enable = rf_enable_c;
    assign bus.rf_read   = rf_read_c;
    assign bus.rf_write  = rf_write_c;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_raddr1 = rf_raddr1_q;
    assign bus.rf_raddr2 = rf_raddr2_q;
    assign bus.rf_din    = rf_din_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed testbench for rf_access_ctrl with a behavioural 32-entry
// register file that samples strobes on negedge.
module tb_rf_access_ctrl;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;
    int writeCount;
    logic bothSeen;

    logic [7:0] mem [32];

    logic [7:0] d1;
    logic [7:0] d2;
    int         lat;
    logic [7:0] expSum;

    rf_access_ctrl_if #(.ADSize(5), .DASize(8)) bus ();

    rf_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: writes and reads happen on negedge when enabled.
    always @(negedge clk) begin
        if (bus.rf_read && bus.rf_write) bothSeen <= 1'b1;
        if (bus.rf_enable && bus.rf_write) begin
            mem[bus.rf_waddr] <= bus.rf_din;
            writeCount <= writeCount + 1;
        end
        if (bus.rf_enable && bus.rf_read) begin
            bus.rf_out1 <= mem[bus.rf_raddr1];
            bus.rf_out2 <= mem[bus.rf_raddr2];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Wait for IDLE, present one command for exactly one accepted cycle;
    // returns #1 after the accepting posedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] a,
                                 input logic [4:0] b, input logic [4:0] d,
                                 input logic [7:0] data);
        int waited;
        waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_addr_d = d;
        bus.cmd_data   = data;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
    endtask

    // Count cycles from accept to rsp_valid, then complete the handshake
    // (rsp_ready is already high).
    task automatic getRsp(output logic [7:0] r1, output logic [7:0] r2, output int cycles);
        cycles = 0;
        while (!bus.rsp_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 20) checkOutput("rsp_timeout", 32'd0, 32'd1);
        r1 = bus.rsp_data1;
        r2 = bus.rsp_data2;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        writeCount  = 0;
        bothSeen    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        bus.rf_out1    = 8'h00;
        bus.rf_out2    = 8'h00;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_addr_a = '0;
        bus.cmd_addr_b = '0;
        bus.cmd_addr_d = '0;
        bus.cmd_data   = '0;
        bus.rsp_ready  = 1'b1;
        rst = 1'b0;

        // Reset for two cycles.
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("rst_rf_enable", bus.rf_enable, 1'b0);
        checkOutput("rst_rf_read",   bus.rf_read,   1'b0);
        checkOutput("rst_rf_write",  bus.rf_write,  1'b0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1'b0);
        checkOutput("rst_rf_waddr",  bus.rf_waddr,  5'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

        // WRITE r3=A5: strobe in the cycle after accept, ready again after 2.
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd3, 8'hA5);
        checkOutput("wr_strobe",     bus.rf_write,  1'b1);
        checkOutput("wr_waddr",      bus.rf_waddr,  5'd3);
        checkOutput("wr_cmd_ready0", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        checkOutput("wr_cmd_ready1", bus.cmd_ready, 1'b1);
        checkOutput("wr_strobe_off", bus.rf_write,  1'b0);
        checkOutput("wr_waddr_hold", bus.rf_waddr,  5'd3);

        // READ a=3 b=0.
        applyStimulus(2'b10, 5'd3, 5'd0, 5'd0, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("rd3_data1", d1, 8'hA5);
        checkOutput("rd3_data2", d2, 8'h00);
        checkOutput("rd_latency", lat, 3);
        checkOutput("rd_valid_drop", bus.rsp_valid, 1'b0);
        checkOutput("rd_idle_ready", bus.cmd_ready, 1'b1);

        // ADD with destination aliasing source A.
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd1, 8'h70);
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd2, 8'h20);
        applyStimulus(2'b11, 5'd1, 5'd2, 5'd1, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("add12_sum",   d1, 8'h90);
        checkOutput("add12_carry", d2, 8'h00);
        checkOutput("add_latency", lat, 4);
        applyStimulus(2'b10, 5'd1, 5'd2, 5'd0, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("rd1_after_add", d1, 8'h90);
        checkOutput("rd2_after_add", d2, 8'h20);

        // ADD with carry out.
`ifdef RFCTL_SAT_EN
        expSum = 8'hFF;
`else
        expSum = 8'h10;
`endif
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd4, 8'hF0);
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd5, 8'h20);
        applyStimulus(2'b11, 5'd4, 5'd5, 5'd6, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("add45_sum",   d1, expSum);
        checkOutput("add45_carry", d2, 8'h01);
        applyStimulus(2'b10, 5'd6, 5'd4, 5'd0, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("rd6_dest", d1, expSum);
        checkOutput("rd4_src",  d2, 8'hF0);

        // Back-pressure: response held while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        applyStimulus(2'b10, 5'd5, 5'd1, 5'd0, 8'h00);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid",     bus.rsp_valid, 1'b1);
            checkOutput("bp_data1",     bus.rsp_data1, 8'h20);
            checkOutput("bp_data2",     bus.rsp_data2, 8'h90);
            checkOutput("bp_cmd_ready", bus.cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_valid_drop", bus.rsp_valid, 1'b0);
        checkOutput("bp_idle_ready", bus.cmd_ready, 1'b1);

        // Highest address.
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd31, 8'h3C);
        applyStimulus(2'b10, 5'd31, 5'd3, 5'd0, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("rd31_data1", d1, 8'h3C);
        checkOutput("rd31_data2", d2, 8'hA5);

        // Reset while an ADD is in RD: no write, no response.
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd7, 8'h11);
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd8, 8'h01);
        applyStimulus(2'b01, 5'd0, 5'd0, 5'd9, 8'h02);
        applyStimulus(2'b11, 5'd8, 5'd9, 5'd7, 8'h00);
        checkOutput("abort_in_rd", bus.rf_read, 1'b1);
        writeCount = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort_no_valid", bus.rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        checkOutput("abort_no_write", writeCount, 0);
        checkOutput("abort_dest_mem", mem[7], 8'h11);
        applyStimulus(2'b10, 5'd7, 5'd8, 5'd0, 8'h00);
        getRsp(d1, d2, lat);
        checkOutput("abort_rd7", d1, 8'h11);
        checkOutput("abort_rd8", d2, 8'h01);

        checkOutput("rd_wr_exclusive", bothSeen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
